// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search sequencer.
package rc4_pkg;

  // Top-level sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_RUN,
    ST_KSA_RUN,
    ST_DEC_RUN,
    ST_CHECK,
    ST_DONE
  } seq_state_t;

  // Which phase FSM currently owns the single S-memory port
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_KSA,
    OWN_DEC
  } s_owner_t;

  // Plaintext alphabet: space plus lowercase letters
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A_LO  = 8'h61;
  localparam logic [7:0] ASCII_Z_LO  = 8'h7A;

  // S-port ownership follows the running phase; idle/check/done own nothing
  function automatic s_owner_t owner_of(input seq_state_t st);
    case (st)
      ST_INIT_RUN: return OWN_INIT;
      ST_KSA_RUN:  return OWN_KSA;
      ST_DEC_RUN:  return OWN_DEC;
      default:     return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_char_screen.sv
// Sticky "bad plaintext" flag: cleared at the start of each decrypt pass,
// set by any written byte outside {space, 'a'..'z'}.
module rc4_char_screen
  import rc4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_clr,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bad
);

  logic w_plain;
  logic r_bad;

  assign w_plain = (i_data == DATA_W'(ASCII_SPACE)) ||
                   ((i_data >= DATA_W'(ASCII_A_LO)) && (i_data <= DATA_W'(ASCII_Z_LO)));

  // Clear wins; otherwise latch any non-plaintext byte until the next clear
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bad <= 1'b0;
    end else if (i_clr) begin
      r_bad <= 1'b0;
    end else if (i_wren && !w_plain) begin
      r_bad <= 1'b1;
    end
  end

  assign o_bad = r_bad;

endmodule

// File: rtl/rc4_key_search_sequencer.sv
// Key-search sequencer: walks candidate keys, runs S-init / KSA / decrypt
// per key, owns the S-memory mux and stops on the first plaintext-looking key.
module rc4_key_search_sequencer
  import rc4_pkg::*;
#(
  parameter int                KEY_W     = 24,
  parameter logic [KEY_W-1:0]  KEY_FIRST = '0,
  parameter logic [KEY_W-1:0]  KEY_LAST  = KEY_W'(24'h3FFFFF),
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_go,
  output logic [KEY_W-1:0]  o_key,
  output logic              o_init_start,
  input  logic              i_init_finish,
  output logic              o_ksa_start,
  input  logic              i_ksa_finish,
  output logic              o_dec_start,
  input  logic              i_dec_finish,
  input  logic [ADDR_W-1:0] i_init_s_address,
  input  logic [DATA_W-1:0] i_init_s_data,
  input  logic              i_init_s_wren,
  input  logic [ADDR_W-1:0] i_ksa_s_address,
  input  logic [DATA_W-1:0] i_ksa_s_data,
  input  logic              i_ksa_s_wren,
  input  logic [ADDR_W-1:0] i_dec_s_address,
  input  logic [DATA_W-1:0] i_dec_s_data,
  input  logic              i_dec_s_wren,
  output logic [ADDR_W-1:0] o_s_address,
  output logic [DATA_W-1:0] o_s_data,
  output logic              o_s_wren,
  input  logic              i_dec_wren,
  input  logic [DATA_W-1:0] i_dec_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_found
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  s_owner_t         w_owner;
  logic [KEY_W-1:0] r_key;
  logic             r_found;
  logic             r_init_start;
  logic             r_ksa_start;
  logic             r_dec_start;
  logic             w_bad;
  logic             w_go_accept;
  logic             w_last_key;

  assign w_go_accept = i_go && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // ">=" keeps a misconfigured KEY_FIRST > KEY_LAST from running away
  assign w_last_key  = (r_key >= KEY_LAST);

  rc4_char_screen #(.DATA_W(DATA_W)) u_screen (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clr     ((r_state == ST_KSA_RUN) && i_ksa_finish),
    .i_wren    ((r_state == ST_DEC_RUN) && i_dec_wren),
    .i_data    (i_dec_data),
    .o_bad     (w_bad)
  );

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state logic; finish pulses only matter in their own phase
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_go_accept)   w_next_state = ST_INIT_RUN;
      ST_INIT_RUN:      if (i_init_finish) w_next_state = ST_KSA_RUN;
      ST_KSA_RUN:       if (i_ksa_finish)  w_next_state = ST_DEC_RUN;
      ST_DEC_RUN:       if (i_dec_finish)  w_next_state = ST_CHECK;
      ST_CHECK: begin
        if (!w_bad || w_last_key) w_next_state = ST_DONE;
        else                      w_next_state = ST_INIT_RUN;
      end
      default:          w_next_state = ST_IDLE;
    endcase
  end

  // Status flags and the state-driven S-memory port mux
  always_comb begin
    o_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    o_done      = (r_state == ST_DONE);
    w_owner     = owner_of(r_state);
    o_s_address = '0;
    o_s_data    = '0;
    o_s_wren    = 1'b0;
    case (w_owner)
      OWN_INIT: begin
        o_s_address = i_init_s_address;
        o_s_data    = i_init_s_data;
        o_s_wren    = i_init_s_wren;
      end
      OWN_KSA: begin
        o_s_address = i_ksa_s_address;
        o_s_data    = i_ksa_s_data;
        o_s_wren    = i_ksa_s_wren;
      end
      OWN_DEC: begin
        o_s_address = i_dec_s_address;
        o_s_data    = i_dec_s_data;
        o_s_wren    = i_dec_s_wren;
      end
      default: ;
    endcase
  end

  // One-cycle start pulses, high during the first cycle of each phase
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_init_start <= 1'b0;
      r_ksa_start  <= 1'b0;
      r_dec_start  <= 1'b0;
    end else begin
      r_init_start <= (w_next_state == ST_INIT_RUN) && (r_state != ST_INIT_RUN);
      r_ksa_start  <= (w_next_state == ST_KSA_RUN)  && (r_state != ST_KSA_RUN);
      r_dec_start  <= (w_next_state == ST_DEC_RUN)  && (r_state != ST_DEC_RUN);
    end
  end

  // Candidate key and result flag; key saturates at KEY_LAST
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_key   <= KEY_FIRST;
      r_found <= 1'b0;
    end else if (w_go_accept) begin
      r_key   <= KEY_FIRST;
      r_found <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      if (!w_bad)           r_found <= 1'b1;
      else if (!w_last_key) r_key   <= r_key + KEY_W'(1);
    end
  end

  assign o_key        = r_key;
  assign o_found      = r_found;
  assign o_init_start = r_init_start;
  assign o_ksa_start  = r_ksa_start;
  assign o_dec_start  = r_dec_start;

endmodule
